myproject_mac_share_sched: RTL and testbench

Round-robin scheduler that shares one 14s x 18s -> 29-bit signed multiplier among NUM_REQ requesters, such as dense-layer lanes.
- Each requester streams operand pairs terminated by a last flag.
- The block accumulates each requester's products in a private accumulator and returns one dot-product result per stream, tagged with the requester id.
- Sits between the layer-lane controllers and the shared DSP multiplier.

---
 rtl/myproject_mac_share_sched_if.sv | 28 ++
 rtl/myproject_mac_share_sched.sv | 143 ++++++++++++++
 tb/tb_myproject_mac_share_sched.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/myproject_mac_share_sched_if.sv
// Requester/result handshake bundle for the shared-multiplier MAC scheduler.
// master = upstream lanes + result sink, slave = the scheduler.
interface myproject_mac_share_sched_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned ACC_WIDTH = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*14-1:0] req_a;
  logic [NUM_REQ*18-1:0] req_b;
  logic [NUM_REQ-1:0]    req_last;
  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic [ACC_WIDTH-1:0]  res_data;
  logic                  res_ovf;

  modport master (
    output req_valid, req_a, req_b, req_last, res_ready,
    input  req_ready, res_valid, res_id, res_data, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_last, res_ready,
    output req_ready, res_valid, res_id, res_data, res_ovf
  );
endinterface

// File: rtl/myproject_mac_share_sched.sv
// Round-robin share of one 14s x 18s multiplier among NUM_REQ requesters, with a
// private saturating accumulator per requester and one tagged result per stream.
module myproject_mac_share_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  myproject_mac_share_sched_if.slave        bus,
  output logic                              busy
);

  localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                 stall;
  logic [ID_W-1:0]      ptr_q;
  logic                 hi_any, lo_any, grant_any;
  logic [ID_W-1:0]      hi_id, lo_id, grant_id;
  logic [NUM_REQ-1:0]   grant;

  logic                 s1_valid_q;
  logic [13:0]          s1_a_q;
  logic [17:0]          s1_b_q;
  logic                 s1_last_q;
  logic [ID_W-1:0]      s1_id_q;

  logic [ACC_WIDTH-1:0] acc_q [NUM_REQ];
  logic [NUM_REQ-1:0]   ovf_q;
  logic [NUM_REQ-1:0]   active_q;

  logic                 res_valid_q;
  logic [ID_W-1:0]      res_id_q;
  logic [ACC_WIDTH-1:0] res_data_q;
  logic                 res_ovf_q;

  logic [28:0]          a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0] acc_cur;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] sum_sat;
  logic                 clamp;

  assign stall = res_valid_q & ~bus.res_ready;

  // Lowest valid index above ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_any = 1'b1;
        lo_id  = ID_W'(i);
        if (ID_W'(i) > ptr_q) begin
          hi_any = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
    grant_any = ~stall & ~ap_rst & (hi_any | lo_any);
    grant_id  = hi_any ? hi_id : lo_id;
    grant     = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  end

  assign bus.req_ready = grant;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q      <= ID_W'(NUM_REQ - 1);
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_last_q  <= 1'b0;
      s1_id_q    <= '0;
    end else if (!stall) begin
      s1_valid_q <= grant_any;
      if (grant_any) begin
        ptr_q     <= grant_id;
        s1_a_q    <= bus.req_a[14*grant_id +: 14];
        s1_b_q    <= bus.req_b[18*grant_id +: 18];
        s1_last_q <= bus.req_last[grant_id];
        s1_id_q   <= grant_id;
      end
    end
  end

  // Only the low 29 bits of the product are kept, so a 29-bit multiply suffices.
  always_comb begin
    a_ext   = {{15{s1_a_q[13]}}, s1_a_q};
    b_ext   = {{11{s1_b_q[17]}}, s1_b_q};
    prod    = a_ext * b_ext;
    acc_cur = acc_q[s1_id_q];
    sum     = {acc_cur[ACC_WIDTH-1], acc_cur} + {{(ACC_WIDTH-28){prod[28]}}, prod};
    clamp   = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    sum_sat = sum[ACC_WIDTH-1:0];
    if (clamp) begin
      sum_sat = sum[ACC_WIDTH] ? AccMin : AccMax;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q       <= '0;
      active_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (!stall && s1_valid_q) begin
        if (s1_last_q) begin
          res_valid_q       <= 1'b1;
          res_id_q          <= s1_id_q;
          res_data_q        <= sum_sat;
          res_ovf_q         <= ovf_q[s1_id_q] | clamp;
          acc_q[s1_id_q]    <= '0;
          ovf_q[s1_id_q]    <= 1'b0;
          active_q[s1_id_q] <= 1'b0;
        end else begin
          acc_q[s1_id_q]    <= sum_sat;
          ovf_q[s1_id_q]    <= ovf_q[s1_id_q] | clamp;
          active_q[s1_id_q] <= 1'b1;
        end
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;

  assign busy = s1_valid_q | (|active_q) | res_valid_q;

endmodule

// File: tb/tb_myproject_mac_share_sched.sv
// Scoreboard bench: a reference model predicts grants and per-stream results,
// which are queued at handshake time and compared when the scheduler returns them.
module tb_myproject_mac_share_sched;

  localparam int NR = 4;
  localparam int AW = 32;

  typedef struct {
    logic signed [13:0] a;
    logic signed [17:0] b;
    logic               last;
  } beat_t;

  typedef struct {
    int     id;
    longint data;
    int     ovf;
    int     cyc;
  } res_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic busy, busy29;

  always #5 ap_clk = ~ap_clk;

  myproject_mac_share_sched_if #(.NUM_REQ(NR), .ID_W(2), .ACC_WIDTH(AW)) bus_if ();
  myproject_mac_share_sched_if #(.NUM_REQ(NR), .ID_W(2), .ACC_WIDTH(29)) if29 ();

  myproject_mac_share_sched #(.NUM_REQ(NR), .ID_W(2), .ACC_WIDTH(AW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus_if),
    .busy   (busy)
  );

  myproject_mac_share_sched #(.NUM_REQ(NR), .ID_W(2), .ACC_WIDTH(29)) dut29 (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (if29),
    .busy   (busy29)
  );

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     mptr = NR - 1;
  int     hold_cnt = 0;
  bit     hold_arm = 1'b0;
  bit     lat_chk = 1'b0;
  bit     rnd_ready = 1'b0;
  beat_t  bq[NR][$];
  res_t   expq[$];
  longint macc[NR];
  bit     mo[NR];

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int r, input int a, input int b, input bit last);
    beat_t bt;
    bt.a = 14'(a);
    bt.b = 18'(b);
    bt.last = last;
    bq[r].push_back(bt);
  endtask

  function automatic bit pending();
    bit p = (expq.size() > 0);
    for (int i = 0; i < NR; i++) begin
      if (bq[i].size() > 0) p = 1'b1;
    end
    return p;
  endfunction

  task automatic model_beat(input int r);
    beat_t  bt;
    longint p, s, mx, mn;
    bit     cl;
    res_t   e;
    bt = bq[r].pop_front();
    p  = longint'(bt.a) * longint'(bt.b);
    p  = (p <<< 35) >>> 35;
    s  = macc[r] + p;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -(longint'(1) <<< (AW - 1));
    cl = 1'b0;
    if (s > mx) begin
      s = mx;
      cl = 1'b1;
    end else if (s < mn) begin
      s = mn;
      cl = 1'b1;
    end
    if (bt.last) begin
      e.id = r;
      e.data = s;
      e.ovf = int'(mo[r] | cl);
      e.cyc = cyc;
      expq.push_back(e);
      macc[r] = 0;
      mo[r] = 1'b0;
    end else begin
      macc[r] = s;
      mo[r] = mo[r] | cl;
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1;
    bus_if.req_valid = '0;
    bus_if.res_ready = 1'b1;
    if29.req_valid = '0;
    if29.res_ready = 1'b1;
    @(negedge ap_clk);
    chk("rst_req_ready", bus_if.req_ready, 0);
    chk("rst_res_valid", bus_if.res_valid, 0);
    chk("rst_res_id", bus_if.res_id, 0);
    chk("rst_res_data", bus_if.res_data, 0);
    chk("rst_res_ovf", bus_if.res_ovf, 0);
    chk("rst_busy", busy, 0);
    ap_rst = 1'b0;
    mptr = NR - 1;
    expq.delete();
    for (int i = 0; i < NR; i++) begin
      bq[i].delete();
      macc[i] = 0;
      mo[i] = 1'b0;
    end
    hold_cnt = 0;
    hold_arm = 1'b0;
  endtask

  task automatic step();
    logic [NR-1:0]    v, vl, rdy, ev, hs;
    logic [NR*14-1:0] va;
    logic [NR*18-1:0] vb;
    bit               stall;
    int               j;
    res_t             r;
    @(negedge ap_clk);
    cyc++;
    if (hold_arm && bus_if.res_valid) begin
      hold_cnt = 5;
      hold_arm = 1'b0;
    end
    bus_if.res_ready = (hold_cnt == 0) && (!rnd_ready || ($urandom_range(0, 3) != 0));
    if (hold_cnt > 0) hold_cnt--;
    v = '0; vl = '0; va = '0; vb = '0;
    for (int i = 0; i < NR; i++) begin
      if (bq[i].size() > 0) begin
        v[i] = 1'b1;
        vl[i] = bq[i][0].last;
        va[14*i +: 14] = bq[i][0].a;
        vb[18*i +: 18] = bq[i][0].b;
      end
    end
    bus_if.req_valid = v;
    bus_if.req_last = vl;
    bus_if.req_a = va;
    bus_if.req_b = vb;
    #1;
    rdy = bus_if.req_ready;
    stall = bus_if.res_valid && !bus_if.res_ready;
    ev = '0;
    if (!stall) begin
      for (int k = 1; k <= NR; k++) begin
        j = (mptr + k) % NR;
        if (ev == '0 && v[j]) ev[j] = 1'b1;
      end
    end
    chk("grant", rdy, ev);
    hs = v & rdy;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        mptr = i;
        model_beat(i);
      end
    end
    if (bus_if.res_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_res", 1, 0);
      end else if (bus_if.res_ready) begin
        r = expq.pop_front();
        chk("res_id", bus_if.res_id, r.id);
        chk("res_data", $signed(bus_if.res_data), r.data);
        chk("res_ovf", bus_if.res_ovf, r.ovf);
        if (lat_chk) chk("latency", cyc - r.cyc, 2);
      end else begin
        chk("held_id", bus_if.res_id, expq[0].id);
        chk("held_data", $signed(bus_if.res_data), expq[0].data);
      end
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((pending() || busy) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("drain_timeout", n, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic beat29(input int a, input int b, input logic last);
    logic [NR*14-1:0] va;
    logic [NR*18-1:0] vb;
    int               n;
    va = '0; vb = '0; n = 0;
    va[27:14] = 14'(a);
    vb[35:18] = 18'(b);
    @(negedge ap_clk);
    if29.req_valid = 4'b0010;
    if29.req_a = va;
    if29.req_b = vb;
    if29.req_last = {2'b00, last, 1'b0};
    #1;
    while (!if29.req_ready[1] && n < 20) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    chk("t4_handshake", longint'(n < 20), 1);
  endtask

  task automatic res29(input longint d, input int o);
    int n = 0;
    @(negedge ap_clk);
    if29.req_valid = '0;
    #1;
    while (!if29.res_valid && n < 20) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    chk("t4_res_valid", if29.res_valid, 1);
    chk("t4_res_id", if29.res_id, 1);
    chk("t4_res_data", $signed(if29.res_data), d);
    chk("t4_res_ovf", if29.res_ovf, o);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus_if.req_valid = '0;
    bus_if.req_last = '0;
    bus_if.req_a = '0;
    bus_if.req_b = '0;
    bus_if.res_ready = 1'b1;
    if29.req_valid = '0;
    if29.req_last = '0;
    if29.req_a = '0;
    if29.req_b = '0;
    if29.res_ready = 1'b1;
    do_reset();

    // Single requester, three-beat stream.
    lat_chk = 1'b1;
    push(0, 3, -5, 1'b0);
    push(0, 4, 6, 1'b0);
    push(0, -2, 7, 1'b1);
    drain(50);

    // All requesters valid, single-beat streams, round-robin order.
    do_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NR; i++) push(i, i + 1, 10, 1'b1);
    drain(60);

    // Same with the sink stalled for five cycles after the first result.
    do_reset();
    lat_chk = 1'b0;
    hold_arm = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NR; i++) push(i, i + 1, 10, 1'b1);
    drain(80);

    // Saturation on the 29-bit accumulator instance, then a clean stream.
    beat29(2048, 131071, 1'b0);
    beat29(2048, 131071, 1'b1);
    res29(268435455, 1);
    beat29(1, 1, 1'b1);
    res29(1, 0);

    // Reset mid-stream discards the partial sum.
    do_reset();
    push(2, 100, 3, 1'b0);
    push(2, 7, 2, 1'b0);
    step();
    step();
    step();
    do_reset();
    chk("post_rst_busy", busy, 0);
    lat_chk = 1'b1;
    push(3, 1, 1, 1'b1);
    push(2, 5, 5, 1'b1);
    drain(50);

    // Interleaved streams on requesters 0 and 3.
    do_reset();
    push(0, 1, 1, 1'b0);
    push(3, 2, 2, 1'b0);
    push(0, 1, 1, 1'b1);
    push(3, 2, 2, 1'b1);
    drain(50);

    // Random interleaving with random backpressure, including wrapping products.
    do_reset();
    lat_chk = 1'b0;
    rnd_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      push($urandom_range(0, NR - 1), int'($urandom_range(0, 16383)) - 8192,
           int'($urandom_range(0, 262143)) - 131072, ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < NR; i++) push(i, 8191, 131071, 1'b1);
    drain(2000);
    rnd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
